// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_r, state_next_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, quo_r, rem_r, dvs_r, result_r;
    logic [CW-1:0]    cnt_r;
    logic             qsign_r, rsign_r, div0_r, ovf_r, done_r, ready_r;

    logic             signed_s, div0_s, ovf_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s, q_fix_s, r_fix_s, res_s;
    logic [WIDTH:0]   shift_s, trial_s;

    assign signed_s = ~op_r[0];
    assign div0_s   = (b_r == ZERO);
    assign ovf_s    = signed_s && (a_r == MIN_NEG) && (b_r == ALL_ONES);
    assign abs_a_s  = (signed_s && a_r[WIDTH-1]) ? (ZERO - a_r) : a_r;
    assign abs_b_s  = (signed_s && b_r[WIDTH-1]) ? (ZERO - b_r) : b_r;
    // Borrow out of the WIDTH+1-bit subtract marks a negative trial remainder.
    assign shift_s  = {rem_r, quo_r[WIDTH-1]};
    assign trial_s  = shift_s - {1'b0, dvs_r};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = PREP;
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef DIV_EARLY_OUT_EN
            PREP: begin
                if (div0_s || ovf_s) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = ITER;
                end
            end
`else
            PREP: state_next_s = ITER;
`endif
            ITER: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = ITER;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Sign fix-up and forced ISA results for divide-by-zero and signed overflow
    always_comb begin
        q_fix_s = quo_r;
        r_fix_s = rem_r;
        if (div0_r) begin
            q_fix_s = ALL_ONES;
            r_fix_s = a_r;
        end else if (ovf_r) begin
            q_fix_s = a_r;
            r_fix_s = ZERO;
        end else begin
            q_fix_s = qsign_r ? (ZERO - quo_r) : quo_r;
            r_fix_s = rsign_r ? (ZERO - rem_r) : rem_r;
        end
        res_s = op_r[1] ? r_fix_s : q_fix_s;
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_r     <= 2'b00;
            a_r      <= ZERO;
            b_r      <= ZERO;
            quo_r    <= ZERO;
            rem_r    <= ZERO;
            dvs_r    <= ZERO;
            cnt_r    <= {CW{1'b0}};
            qsign_r  <= 1'b0;
            rsign_r  <= 1'b0;
            div0_r   <= 1'b0;
            ovf_r    <= 1'b0;
            result_r <= ZERO;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            done_r  <= 1'b0;
            ready_r <= (state_next_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                    end
                end
                PREP: begin
                    quo_r   <= abs_a_s;
                    dvs_r   <= abs_b_s;
                    rem_r   <= ZERO;
                    cnt_r   <= CW'(WIDTH - 1);
                    qsign_r <= signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    rsign_r <= signed_s & a_r[WIDTH-1];
                    div0_r  <= div0_s;
                    ovf_r   <= ovf_s;
                end
                ITER: begin
                    if (!trial_s[WIDTH]) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= shift_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - CW'(1);
                end
                FIX: begin
                    result_r <= res_s;
                    done_r   <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit (default build: uniform WIDTH+2 latency).
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        ready, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
    localparam int LAT = 34;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with ready=1; returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          output logic [31:0] res_o, output int lat_o, output int busy_bad_o);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        lat_o = -1;
        busy_bad_o = 0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3, 0));
        if (ready !== 1'b0 || done !== 1'b0) busy_bad_o++;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done === 1'b1) begin
                lat_o = i;
                break;
            end
            if (ready !== 1'b0) busy_bad_o++;
        end
        res_o = result;
    endtask

    initial begin
        logic [31:0] res;
        int          lat, busy_bad, done_cnt, ready_bad;

        vecs[0]  = '{OP_DIV,  32'hFFFFFFE2, 32'd3,        32'hFFFFFFF6};
        vecs[1]  = '{OP_DIVU, 32'd31,       32'd3,        32'd10};
        vecs[2]  = '{OP_REM,  32'd31,       32'd3,        32'd1};
        vecs[3]  = '{OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[5]  = '{OP_REMU, 32'd5,        32'd0,        32'd5};
        vecs[6]  = '{OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[7]  = '{OP_REM,  32'd5,        32'd0,        32'd5};
        vecs[8]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[9]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[10] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[11] = '{OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[12] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[13] = '{OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1};
        vecs[14] = '{OP_REMU, 32'd100,      32'd7,        32'd2};
        vecs[15] = '{OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFE, 32'd4};
        vecs[16] = '{OP_REM,  32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE};
        vecs[17] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
        vecs[18] = '{OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
        vecs[19] = '{OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clock);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Vectors issue back-to-back: each new start lands in the previous done cycle.
        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_bad);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_busy_flags", i), 32'(busy_bad), 32'd0);
            check($sformatf("vec%0d_ready_in_done", i), {31'd0, ready}, 32'd1);
        end
        start = 1'b0;
        @(negedge clock);
        check("done_single_pulse", {31'd0, done}, 32'd0);

        // Start pulse while busy must be ignored and not queued.
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        lat = -1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (i == 5) begin
                start = 1'b1; op = OP_REM; a = 32'd1000; b = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_start_result", result, 32'd14);
        check("busy_start_latency", 32'(lat), 32'(LAT));
        ready_bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (ready !== 1'b1 || done !== 1'b0) ready_bad++;
        end
        check("busy_start_not_queued", 32'(ready_bad), 32'd0);

        // Reset in the middle of a run aborts it without a done pulse.
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_result_held", result, 32'd0);

        run_op(OP_DIV, 32'd100, 32'hFFFFFFF9, res, lat, busy_bad);
        check("post_reset_result", res, 32'hFFFFFFF2);
        check("post_reset_latency", 32'(lat), 32'(LAT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
